io_uart_bridge: RTL and testbench

- Peripheral-side responder for the core IO unit's byte handshake channels.
- Serves the IN channel: core raises io_in_rdy and waits for io_in_vld. Serves the OUT channel: core raises io_out_vld and waits for io_out_rdy.
- Bytes received on a UART RX line are buffered in an RX FIFO and presented on the IN channel. Bytes accepted on the OUT channel are buffered in a TX FIFO and serialised on a UART TX line.
- Sits between the core top level and the board's UART pins.

---
 rtl/io_uart_bridge.sv | 210 +++++++++++++++++++++
 tb/tb_io_uart_bridge.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/io_uart_bridge.sv
// Byte handshake responder for the core IO unit: UART RX -> RX FIFO -> IN channel,
// OUT channel -> TX FIFO -> UART TX.
module io_uart_bridge #(
  parameter int CLKS_PER_BIT  = 868,
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rstn,
  output logic [7:0] io_in_data,
  input  logic       io_in_rdy,
  output logic       io_in_vld,
  input  logic [7:0] io_out_data,
  output logic       io_out_rdy,
  input  logic       io_out_vld,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam int RXD = 1 << RX_DEPTH_LOG2;
  localparam int TXD = 1 << TX_DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_e;

  logic [7:0]             rx_mem_q [RXD];
  logic [RX_DEPTH_LOG2:0] rx_wptr_q, rx_rptr_q;
  logic                   rx_empty_s, rx_full_s, rx_push_s, rx_pop_s;
  logic                   rx_sync1_q, rx_sync2_q, rx_s;
  state_e                 rx_state_q;
  logic [CW-1:0]          rx_cnt_q;
  logic [2:0]             rx_idx_q;
  logic [7:0]             rx_shift_q;
  logic                   rx_overrun_q, rx_frame_err_q;

  logic [7:0]             tx_mem_q [TXD];
  logic [TX_DEPTH_LOG2:0] tx_wptr_q, tx_rptr_q;
  logic                   tx_empty_s, tx_full_s, tx_push_s, tx_pop_s;
  logic [7:0]             tx_head_s;
  state_e                 tx_state_q;
  logic [CW-1:0]          tx_cnt_q;
  logic [2:0]             tx_idx_q;
  logic [7:0]             tx_shift_q;
  logic                   uart_tx_q;

  assign rx_s       = rx_sync2_q;
  assign rx_empty_s = (rx_wptr_q == rx_rptr_q);
  assign rx_full_s  = (rx_wptr_q[RX_DEPTH_LOG2] != rx_rptr_q[RX_DEPTH_LOG2]) &&
                      (rx_wptr_q[RX_DEPTH_LOG2-1:0] == rx_rptr_q[RX_DEPTH_LOG2-1:0]);
  assign io_in_vld  = !rx_empty_s;
  assign io_in_data = rx_empty_s ? 8'd0 : rx_mem_q[rx_rptr_q[RX_DEPTH_LOG2-1:0]];
  assign rx_pop_s   = io_in_vld && io_in_rdy;
  // A pop in the stop-sample cycle frees the slot the new byte needs.
  assign rx_push_s  = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_END) && rx_s &&
                      (!rx_full_s || rx_pop_s);

  assign tx_empty_s = (tx_wptr_q == tx_rptr_q);
  assign tx_full_s  = (tx_wptr_q[TX_DEPTH_LOG2] != tx_rptr_q[TX_DEPTH_LOG2]) &&
                      (tx_wptr_q[TX_DEPTH_LOG2-1:0] == tx_rptr_q[TX_DEPTH_LOG2-1:0]);
  assign io_out_rdy = !tx_full_s;
  assign tx_push_s  = io_out_vld && io_out_rdy;
  assign tx_head_s  = tx_mem_q[tx_rptr_q[TX_DEPTH_LOG2-1:0]];
  assign tx_pop_s   = !tx_empty_s &&
                      ((tx_state_q == S_IDLE) || ((tx_state_q == S_STOP) && (tx_cnt_q == BIT_END)));

  assign uart_tx      = uart_tx_q;
  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

  // FIFO storage; contents are don't-care while the matching pointers say empty.
  always_ff @(posedge clk) begin
    if (rx_push_s) rx_mem_q[rx_wptr_q[RX_DEPTH_LOG2-1:0]] <= rx_shift_q;
    if (tx_push_s) tx_mem_q[tx_wptr_q[TX_DEPTH_LOG2-1:0]] <= io_out_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
    end else begin
      if (rx_push_s) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop_s)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (tx_push_s) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop_s)  tx_rptr_q <= tx_rptr_q + 1'b1;
    end
  end

  // Receiver: synchroniser, mid-bit sampling FSM and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_sync1_q     <= 1'b1;
      rx_sync2_q     <= 1'b1;
      rx_state_q     <= S_IDLE;
      rx_cnt_q       <= '0;
      rx_idx_q       <= 3'd0;
      rx_shift_q     <= 8'd0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      rx_sync1_q <= uart_rx;
      rx_sync2_q <= rx_sync1_q;
      case (rx_state_q)
        S_IDLE: begin
          rx_cnt_q <= '0;
          if (!rx_s) rx_state_q <= S_START;
        end
        S_START: begin
          if (rx_cnt_q == HALF_END) begin
            rx_cnt_q   <= '0;
            rx_idx_q   <= 3'd0;
            rx_state_q <= rx_s ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_s, rx_shift_q[7:1]};
            rx_idx_q   <= rx_idx_q + 3'd1;
            if (rx_idx_q == 3'd7) rx_state_q <= S_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            if (!rx_s)                        rx_frame_err_q <= 1'b1;
            else if (rx_full_s && !rx_pop_s)  rx_overrun_q   <= 1'b1;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  // Transmitter: back-to-back frames when the FIFO still holds data at stop end.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      uart_tx_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          tx_cnt_q <= '0;
          if (!tx_empty_s) begin
            tx_shift_q <= tx_head_s;
            uart_tx_q  <= 1'b0;
            tx_state_q <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q   <= '0;
            tx_idx_q   <= 3'd0;
            uart_tx_q  <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_state_q <= S_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_idx_q == 3'd7) begin
              uart_tx_q  <= 1'b1;
              tx_state_q <= S_STOP;
            end else begin
              uart_tx_q  <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_idx_q   <= tx_idx_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (!tx_empty_s) begin
              tx_shift_q <= tx_head_s;
              uart_tx_q  <= 1'b0;
              tx_state_q <= S_START;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart_bridge.sv
// Randomised bench for io_uart_bridge: UART frames are predicted from the byte
// values with plain arithmetic and the RX side is modelled as a bounded queue.
module tb_io_uart_bridge;
  localparam int CPB   = 8;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] io_in_data;
  logic       io_in_rdy;
  logic       io_in_vld;
  logic [7:0] io_out_data;
  logic       io_out_rdy;
  logic       io_out_vld;
  logic       uart_rx;
  logic       uart_tx;
  logic       rx_overrun;
  logic       rx_frame_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic       exp_overrun = 1'b0;
  logic       exp_ferr    = 1'b0;

  always #5 clk = ~clk;

  io_uart_bridge #(.CLKS_PER_BIT(CPB), .RX_DEPTH_LOG2(4), .TX_DEPTH_LOG2(4)) dut (
    .clk(clk), .rstn(rstn),
    .io_in_data(io_in_data), .io_in_rdy(io_in_rdy), .io_in_vld(io_in_vld),
    .io_out_data(io_out_data), .io_out_rdy(io_out_rdy), .io_out_vld(io_out_vld),
    .uart_rx(uart_rx), .uart_tx(uart_tx),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Line level of position pos (0 = start bit, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int pos);
    if (pos == 0)      return 1'b0;
    else if (pos <= 8) return b[pos-1];
    else               return 1'b1;
  endfunction

  task automatic check_in(input string tag);
    check_eq({tag, "_vld"},  32'(io_in_vld), 32'(rx_q.size() > 0));
    check_eq({tag, "_data"}, 32'(io_in_data), 32'((rx_q.size() > 0) ? rx_q[0] : 8'd0));
  endtask

  task automatic check_flags(input string tag);
    check_eq({tag, "_ovr"}, 32'(rx_overrun),   32'(exp_overrun));
    check_eq({tag, "_fer"}, 32'(rx_frame_err), 32'(exp_ferr));
  endtask

  // Drives one frame starting just after a falling edge and updates the RX model.
  task automatic rx_frame(input logic [7:0] b, input logic stop_bit);
    for (int pos = 0; pos < 10; pos++) begin
      uart_rx = (pos == 9) ? stop_bit : frame_bit(b, pos);
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
    if (!stop_bit)              exp_ferr = 1'b1;
    else if (rx_q.size() < DEPTH) rx_q.push_back(b);
    else                        exp_overrun = 1'b1;
  endtask

  task automatic pop_in();
    io_in_rdy = 1'b1;
    @(negedge clk);
    io_in_rdy = 1'b0;
    if (rx_q.size() > 0) void'(rx_q.pop_front());
  endtask

  // Pushes tx_q back-to-back and checks the serial line cycle by cycle.
  task automatic tx_run();
    int n;
    n = tx_q.size();
    io_out_vld  = 1'b1;
    io_out_data = tx_q[0];
    fork
      begin : pusher
        int occ;
        for (int i = 0; i < n; i++) begin
          occ = (i <= 1) ? i : i - 1;
          check_eq("out_rdy_push", 32'(io_out_rdy), 32'(occ < DEPTH));
          @(negedge clk);
          if (i + 1 < n) io_out_data = tx_q[i+1];
          else           io_out_vld  = 1'b0;
        end
        if (n > DEPTH) check_eq("out_rdy_full", 32'(io_out_rdy), 32'(0));
      end
      begin : line_chk
        logic exp_b;
        @(posedge clk);
        @(posedge clk);
        for (int t = 0; t < n * FRAME + 2 * CPB; t++) begin
          @(negedge clk);
          exp_b = (t < n * FRAME) ? frame_bit(tx_q[t / FRAME], (t % FRAME) / CPB) : 1'b1;
          check_eq("tx_line", 32'(uart_tx), 32'(exp_b));
          if (n > DEPTH && t == FRAME + 10)
            check_eq("out_rdy_after_pop", 32'(io_out_rdy), 32'(1));
        end
      end
    join
  endtask

  initial begin
    rstn = 1'b0; io_in_rdy = 1'b0; io_out_vld = 1'b0; io_out_data = 8'd0; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_tx", 32'(uart_tx), 32'(1));
    check_eq("rst_out_rdy", 32'(io_out_rdy), 32'(1));
    check_in("rst");
    check_flags("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    tx_q = {8'hA5};
    tx_run();

    tx_q = {};
    for (int i = 0; i < DEPTH + 1; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    tx_run();

    rx_frame(8'h3C, 1'b1);
    check_in("in_3c");
    pop_in();
    check_in("in_popped");

    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_in("glitch");

    for (int i = 0; i < DEPTH + 1; i++) begin
      rx_frame(8'($urandom_range(0, 255)), 1'b1);
      if (i == DEPTH - 1) check_flags("ovr_before");
    end
    check_flags("ovr_after");
    for (int i = 0; i < DEPTH; i++) begin
      check_in("drain");
      pop_in();
    end
    check_in("drained");

    rx_frame(8'h55, 1'b0);
    repeat (2 * CPB) @(negedge clk);
    check_flags("ferr");
    check_in("ferr_nopush");
    rx_frame(8'h12, 1'b1);
    check_in("after_ferr");

    io_out_vld = 1'b1;
    io_out_data = 8'h00;
    @(negedge clk);
    io_out_vld = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("pre_rst_tx", 32'(uart_tx), 32'(frame_bit(8'h00, 19 / CPB)));
    #2 rstn = 1'b0;
    #1;
    rx_q = {};
    exp_overrun = 1'b0;
    exp_ferr = 1'b0;
    check_eq("midrst_tx", 32'(uart_tx), 32'(1));
    check_eq("midrst_out_rdy", 32'(io_out_rdy), 32'(1));
    check_in("midrst");
    check_flags("midrst");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", 32'(uart_tx), 32'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
